// File: rtl/dpram_arb_pkg.sv
// Shared widths and the registered RAM command type for the dual-port RAM arbiter.
package dpram_arb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int ID_W   = 2;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner when adv_i is set.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   win_o,
  output logic               vld_o
);
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    vld_o = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!vld_o && req_i[idx]) begin
        vld_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        win_o      = idx;
      end
    end
    ptr_d = (win_o == PTR_W'(NUM_REQ - 1)) ? '0 : win_o + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (adv_i && vld_o) begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/dpram_arbiter.sv
// Shares one 32x8 dual-port RAM between NUM_REQ clients with independent write/read
// round-robin arbitration and same-address read deferral.
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ram_enb,
  output logic                      ram_wr,
  output logic [ADDR_W-1:0]         ram_w_addr,
  output logic [DATA_W-1:0]         ram_w_data,
  output logic                      ram_rd,
  output logic [ADDR_W-1:0]         ram_r_addr,
  input  logic [DATA_W-1:0]         ram_r_data
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] wmask, wreq, rreq, wgnt, rgnt_raw, rgnt;
  logic [PTR_W-1:0]   wwin, rwin;
  logic               wvld, rvld, collide;
  logic [ADDR_W-1:0]  w_addr, r_addr;
  logic [DATA_W-1:0]  w_data;

  cmd_t               wcmd_q, wcmd_d;
  logic               rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [PTR_W-1:0]   rd_id_q, rd_id_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic               blk_valid_q, blk_valid_d;
  logic [ADDR_W-1:0]  blk_addr_q, blk_addr_d;

  // The cycle after a deferral, writes to the blocked address step aside so the read wins.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wmask[i] = blk_valid_q && (addr[i*ADDR_W +: ADDR_W] == blk_addr_q);
    end
  end

  assign wreq = req & we & ~wmask;
  assign rreq = req & ~we;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_warb (
    .clk_i(clk), .rst_ni(rst), .req_i(wreq), .adv_i(1'b1),
    .gnt_o(wgnt), .win_o(wwin), .vld_o(wvld)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rarb (
    .clk_i(clk), .rst_ni(rst), .req_i(rreq), .adv_i(!collide),
    .gnt_o(rgnt_raw), .win_o(rwin), .vld_o(rvld)
  );

  assign w_addr  = addr[int'(wwin)*ADDR_W +: ADDR_W];
  assign w_data  = wdata[int'(wwin)*DATA_W +: DATA_W];
  assign r_addr  = addr[int'(rwin)*ADDR_W +: ADDR_W];
  assign collide = wvld && rvld && (w_addr == r_addr);
  assign rgnt    = collide ? '0 : rgnt_raw;
  assign gnt     = rst ? (wgnt | rgnt) : '0;

  always_comb begin
    wcmd_d = '0;
    if (wvld) begin
      wcmd_d.valid = 1'b1;
      wcmd_d.addr  = w_addr;
      wcmd_d.data  = w_data;
      wcmd_d.id    = ID_W'(wwin);
    end
    rd_vld_d    = rvld && !collide;
    rd_addr_d   = rd_vld_d ? r_addr : '0;
    rd_id_d     = rd_vld_d ? rwin : '0;
    blk_valid_d = collide;
    blk_addr_d  = collide ? r_addr : blk_addr_q;
    rvalid_d    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid_d[i] = rd_vld_q && (rd_id_q == PTR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcmd_q      <= '0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_id_q     <= '0;
      rvalid_q    <= '0;
      blk_valid_q <= 1'b0;
      blk_addr_q  <= '0;
    end else begin
      wcmd_q      <= wcmd_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_q   <= rd_addr_d;
      rd_id_q     <= rd_id_d;
      rvalid_q    <= rvalid_d;
      blk_valid_q <= blk_valid_d;
      blk_addr_q  <= blk_addr_d;
    end
  end

  assign ram_wr     = wcmd_q.valid;
  assign ram_w_addr = wcmd_q.addr;
  assign ram_w_data = wcmd_q.data;
  assign ram_rd     = rd_vld_q;
  assign ram_r_addr = rd_addr_q;
  assign ram_enb    = wcmd_q.valid | rd_vld_q;
  assign rvalid     = rvalid_q;
  assign rdata      = ram_r_data;
endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: behavioural RAM, shadow-memory scoreboard for read returns, directed scenarios.
module tb_dpram_arbiter;
  import dpram_arb_pkg::*;
  localparam int NUM_REQ = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NUM_REQ-1:0]        req, we, gnt, rvalid;
  logic [ADDR_W-1:0]         a_arr [NUM_REQ];
  logic [DATA_W-1:0]         d_arr [NUM_REQ];
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [DATA_W-1:0]         rdata, ram_w_data, ram_r_data;
  logic [ADDR_W-1:0]         ram_w_addr, ram_r_addr;
  logic                      ram_enb, ram_wr, ram_rd;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign addr[g*ADDR_W +: ADDR_W]  = a_arr[g];
    assign wdata[g*DATA_W +: DATA_W] = d_arr[g];
  end

  dpram_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_enb(ram_enb),
    .ram_wr(ram_wr), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_rd(ram_rd), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_enb && ram_rd) ram_r_data <= mem[ram_r_addr];
    if (ram_enb && ram_wr) mem[ram_w_addr] <= ram_w_data;
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int                id;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t sb [$];

  logic [DATA_W-1:0]  shadow [DEPTH];
  logic [NUM_REQ-1:0] p_pend;
  logic               p_we [NUM_REQ];
  logic [ADDR_W-1:0]  p_a  [NUM_REQ];
  logic [DATA_W-1:0]  p_d  [NUM_REQ];

  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      p_pend <= '0;
    end else begin
      chk("gnt_sub_req", 32'(gnt & ~req), 0);
      chk("wgnt_onehot", 32'($countones(gnt & we) <= 1), 1);
      chk("rgnt_onehot", 32'($countones(gnt & ~we) <= 1), 1);
      for (int k = 0; k < NUM_REQ; k++) begin
        if (p_pend[k])
          chk("proto_hold", 32'({req[k], we[k], a_arr[k], d_arr[k]}),
              32'({1'b1, p_we[k], p_a[k], p_d[k]}));
        if (req[k] && gnt[k] && !we[k]) sb.push_back('{k, shadow[a_arr[k]], cyc + 2});
        if (req[k] && gnt[k] && we[k]) shadow[a_arr[k]] <= d_arr[k];
        p_pend[k] <= req[k] & ~gnt[k];
        p_we[k]   <= we[k];
        p_a[k]    <= a_arr[k];
        p_d[k]    <= d_arr[k];
      end
      if (rvalid != '0) begin
        if (sb.size() == 0) begin
          chk("rv_spurious", 32'(rvalid), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rv_id", 32'(rvalid), 32'(1) << e.id);
          chk("rv_data", 32'(rdata), 32'(e.data));
          chk("rv_latency", cyc, e.due);
        end
      end
      if (sb.size() != 0 && sb[0].due < cyc) begin
        chk("rv_missing", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input int k, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    req[k]   = 1'b1;
    we[k]    = w;
    a_arr[k] = a;
    d_arr[k] = d;
  endtask

  task automatic idle(input int k);
    req[k] = 1'b0;
  endtask

  initial begin
    req = '0;
    we  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      a_arr[k] = '0;
      d_arr[k] = '0;
    end

    // reset holds everything quiet even with both clients requesting
    drive(0, 1'b1, 5'd1, 8'h10);
    drive(1, 1'b1, 5'd2, 8'h11);
    repeat (2) smp();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_enb", 32'(ram_enb), 0);
    chk("rst_wr", 32'(ram_wr), 0);
    chk("rst_rd", 32'(ram_rd), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_waddr", 32'(ram_w_addr), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // continuous writes from both clients alternate, starting at client 0
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("rr_gnt", 32'(gnt), (i % 2 == 0) ? 1 : 2);
      if (i > 0) begin
        chk("rr_wr", 32'(ram_wr), 1);
        chk("rr_waddr", 32'(ram_w_addr), (i % 2 == 1) ? 1 : 2);
      end
      step();
    end
    idle(1);
    smp();
    chk("rr_tail_gnt", 32'(gnt), 1);
    chk("rr_tail_waddr", 32'(ram_w_addr), 2);
    step();
    idle(0);
    step();
    step();

    // single write then read back
    drive(0, 1'b1, 5'd3, 8'hA5);
    smp();
    chk("wr_gnt", 32'(gnt), 1);
    step();
    idle(0);
    smp();
    chk("wr_cmd", 32'(ram_wr), 1);
    chk("wr_enb", 32'(ram_enb), 1);
    chk("wr_addr", 32'(ram_w_addr), 3);
    chk("wr_data", 32'(ram_w_data), 'hA5);
    step();
    drive(0, 1'b0, 5'd3, 8'h00);
    smp();
    chk("rd_gnt", 32'(gnt), 1);
    step();
    idle(0);
    smp();
    chk("rd_cmd", 32'(ram_rd), 1);
    chk("rd_addr", 32'(ram_r_addr), 3);
    step();
    smp();
    chk("rd_rvalid", 32'(rvalid), 1);
    chk("rd_rdata", 32'(rdata), 'hA5);
    step();

    // preload addr 7, then write and read ports in parallel
    drive(1, 1'b1, 5'd7, 8'h3C);
    smp();
    chk("pre_gnt", 32'(gnt), 2);
    step();
    idle(1);
    step();
    drive(0, 1'b1, 5'd5, 8'h5A);
    drive(1, 1'b0, 5'd7, 8'h00);
    smp();
    chk("par_gnt", 32'(gnt), 3);
    step();
    idle(0);
    idle(1);
    smp();
    chk("par_wr", 32'(ram_wr), 1);
    chk("par_rd", 32'(ram_rd), 1);
    chk("par_waddr", 32'(ram_w_addr), 5);
    chk("par_raddr", 32'(ram_r_addr), 7);
    step();
    smp();
    chk("par_rvalid", 32'(rvalid), 2);
    chk("par_rdata", 32'(rdata), 'h3C);
    step();

    // same-address collision: read deferred, follow-up write masked one cycle
    drive(0, 1'b1, 5'd9, 8'h11);
    drive(1, 1'b0, 5'd9, 8'h00);
    smp();
    chk("col_gnt0", 32'(gnt), 1);
    step();
    drive(0, 1'b1, 5'd9, 8'h22);
    smp();
    chk("col_gnt1", 32'(gnt), 2);
    chk("col_wr1", 32'(ram_wr), 1);
    chk("col_rd1", 32'(ram_rd), 0);
    step();
    idle(1);
    smp();
    chk("col_gnt2", 32'(gnt), 1);
    chk("col_rd2", 32'(ram_rd), 1);
    chk("col_raddr", 32'(ram_r_addr), 9);
    step();
    idle(0);
    smp();
    chk("col_rvalid", 32'(rvalid), 2);
    chk("col_rdata", 32'(rdata), 'h11);
    step();
    drive(1, 1'b0, 5'd9, 8'h00);
    smp();
    chk("col_reread_gnt", 32'(gnt), 2);
    step();
    idle(1);
    repeat (3) step();

    // reset while a granted read is in flight
    drive(0, 1'b0, 5'd3, 8'h00);
    smp();
    chk("mr_gnt", 32'(gnt), 1);
    step();
    idle(0);
    rst = 1'b0;
    #1;
    chk("mr_rd", 32'(ram_rd), 0);
    chk("mr_enb", 32'(ram_enb), 0);
    smp();
    chk("mr_rvalid", 32'(rvalid), 0);
    step();
    rst = 1'b1;
    repeat (3) begin
      smp();
      chk("mr_quiet", 32'(rvalid), 0);
      step();
    end
    drive(0, 1'b1, 5'd4, 8'h01);
    drive(1, 1'b1, 5'd6, 8'h02);
    smp();
    chk("mr_ptr_gnt0", 32'(gnt), 1);
    step();
    idle(0);
    smp();
    chk("mr_ptr_gnt1", 32'(gnt), 2);
    step();
    idle(1);

    repeat (4) step();
    chk("sb_drain", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
- Shares the 32x8 dual-port RAM between NUM_REQ clients.
- Write port and read port are arbitrated independently, each with its own round-robin pointer.
- Issues registered RAM commands and returns read data to the granted client.
- Detects and defers same-address read/write collisions so no read ever observes a collision.

Parameters:
- NUM_REQ, 2, number of clients (2..4).
- ADDR_W, 5, RAM address width (from package).
- DATA_W, 8, RAM data width (from package).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-client request; held with we/addr/wdata stable until gnt.
- we  in  NUM_REQ  per-client 1=write, 0=read.
- addr  in  NUM_REQ*ADDR_W  per-client address.
- wdata  in  NUM_REQ*DATA_W  per-client write data.
- gnt  out  NUM_REQ  combinational grant; transfer occurs when req&gnt.
- rvalid  out  NUM_REQ  one-cycle pulse; read data valid for that client.
- rdata  out  DATA_W  read data, shared by all clients, qualified by rvalid.
- ram_enb  out  1  RAM enable.
- ram_wr  out  1  RAM write strobe.
- ram_w_addr  out  ADDR_W  RAM write address.
- ram_w_data  out  DATA_W  RAM write data.
- ram_rd  out  1  RAM read strobe.
- ram_r_addr  out  ADDR_W  RAM read address.
- ram_r_data  in  DATA_W  RAM read data, valid the cycle after a sampled rd.

Behaviour:
- Reset (rst=0, asynchronous): all ram_* outputs 0, rvalid 0, both round-robin pointers at client 0, block flag clear. gnt is combinational, so it is 0 whenever rst=0.
- Routing: requests with we=1 go to the write arbiter; we=0 go to the read arbiter. At most one gnt per client per cycle; at most one write grant and one read grant per cycle.
- Round-robin: search starts at the pointer. After a grant to client k, that port's pointer becomes (k+1) mod NUM_REQ. With no grant, the pointer holds.
- Grant at cycle T: command registered at end of T. ram_wr/ram_rd and addresses/data are driven during T+1 for exactly one cycle.
- ram_enb = ram_wr | ram_rd (registered). Write and read commands may occur in the same cycle.
- Read return: rvalid[k] pulses during T+2. rdata = ram_r_data, combinational passthrough. Read latency from grant is 2 cycles.
- Collision: if the read winner's addr equals the write winner's addr in the same cycle, the read gnt is withheld.
  - The read pointer does not advance.
  - blk_valid is set and blk_addr is captured.
- Anti-starvation: in the cycle after blk_valid is set, any write request to blk_addr is masked from the write arbiter. The blocked read is then granted; its worst-case extra latency is 1 cycle. blk_valid clears after that cycle.
- A write in T+1 followed by a read of the same address granted in T+1 is legal: the read returns the new data.
- Protocol violations are not supported: dropping req before gnt, or changing we/addr/wdata while req is held. The bench asserts against them.
- Reset mid-operation clears in-flight commands and pending rvalid. No pulse occurs after rst rises.

Decomposition:
- Package dpram_arb_pkg: ADDR_W=5, DATA_W=8, DEPTH=32, and a typedef for the command struct {valid, addr, data, id}.
- Sub-module rr_arbiter (NUM_REQ req vector in, one-hot gnt out, internal pointer with an advance enable). Instantiated twice, once for writes and once for reads.

Test Plan:
- Reset: hold rst=0 with both req=1 -> gnt=00, all ram_* = 0, rvalid=00. Release -> first grants go to client 0.
- Single write then read: client0 writes 0xA5 to addr 3 at T -> ram_wr=1, ram_w_addr=3, ram_w_data=0xA5 at T+1. Client0 reads addr 3 at T+2 -> rvalid[0]=1 and rdata=0xA5 at T+4.
- Round-robin: both clients request writes continuously, addrs 1 and 2 -> gnt alternates 01,10,01,10 and ram_w_addr sequence is 1,2,1,2.
- Parallel ports: client0 writes addr 5 while client1 reads addr 7 (preloaded 0x3C) in the same cycle -> both granted. ram_wr and ram_rd are both 1 at T+1; rvalid[1] with 0x3C at T+2.
- Collision: client0 writes addr 9 = 0x11 and client1 reads addr 9 in the same cycle -> read gnt deferred 1 cycle, and client1 returns 0x11. If client0 immediately writes addr 9 = 0x22, that write is masked for one cycle and the read still returns 0x11.
- Mid-operation reset: assert rst=0 at T+1 of a granted read -> ram_rd=0 immediately and no rvalid pulse after release.
